input_channel_buffer: RTL and testbench
=======================================

# input_channel_buffer

Per-input-port flit buffer for the symmetric butterfly switch, instantiated once per input channel directly upstream of the output-port allocator. Accepts 4-bit flits from the incoming link with a valid/ready handshake, filters malformed packet framing, stores legal flits in a circular FIFO, and presents the oldest flit as the head flit the allocator decodes. The allocator's per-port select for this channel acts as the pop strobe.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- in_flit  input  4  incoming flit: [3:2] type (11 header, 10 payload, 00 null, 01 reserved), [1:0] destination port.
- in_valid  input  1  in_flit is valid this cycle.
- in_ready  output  1  buffer can accept a flit; equals not-full.
- head_flit  output  4  oldest stored flit; 4'b0000 (null) when empty.
- pop  input  1  allocator selected this port; consume head flit.
- count  output  $clog2(DEPTH)+1  number of stored flits, 0..DEPTH.
- drop_err  output  1  one-cycle pulse: a handshaked flit was discarded.

## Operation
- Accept = in_valid & in_ready. Flits are only examined when accepted.
- Framing FSM, states IDLE and PKT, reset to IDLE:
  - header (11) accepted: stored; next state PKT (from either state; a header in PKT starts a new packet).
  - payload (10) accepted in PKT: stored; stay PKT.
  - payload accepted in IDLE: discarded; drop_err pulses; stay IDLE.
  - null (00) accepted: not stored; next state IDLE; no error.
  - reserved (01) accepted: discarded; drop_err pulses; next state IDLE.
- FIFO: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH; count tracked separately to distinguish full (count==DEPTH) from empty (count==0).
- Store writes mem[wr_ptr], wr_ptr+1. Pop with count>0: rd_ptr+1. Pop with count==0 ignored (no pointer or count change, no error).
- Simultaneous store and valid pop: both happen, count unchanged.
- When full, in_ready=0, so no flit is accepted even if pop is asserted that cycle (no pass-through on full).
- head_flit = mem[rd_ptr] when count>0, else 4'b0000, so the allocator sees null on an empty buffer and raises no request.
- Storage contents need no reset; only pointers, count, FSM state and drop_err are reset.

## Timing
- Reset (rst_n low at posedge): count=0, wr_ptr=rd_ptr=0, state IDLE, drop_err=0. Outputs during and after reset: in_ready=1, head_flit=4'b0000, count=0, drop_err=0.
- Reset mid-packet discards all stored flits and framing state; the first accepted flit after reset must be a header or it is dropped.
- Write latency: a flit accepted at edge N appears on head_flit after edge N (visible in cycle N+1) if the buffer was empty.
- Pop latency: pop sampled at edge N; the next flit (or null) appears on head_flit after edge N.
- head_flit, in_ready and count are functions of registered state only; no combinational path from in_flit/in_valid/pop to any output.
- drop_err is registered: asserted for exactly the cycle after the offending accept edge.
- Pointer wrap from DEPTH-1 to 0 is seamless; back-to-back store/pop at one flit per cycle sustains full throughput indefinitely.

## Test plan
- Reset then idle: rst_n low 2 cycles, release -> in_ready=1, count=0, head_flit=0000, drop_err=0.
- Packet in: accept 1110 (header to port 2), 1000, 1000, 0000 with pop=0 -> count=3, head_flit=1110; pop 3 cycles -> head_flit 1000, 1000, then 0000, count 0.
- Full: DEPTH=4, accept header + 3 payloads -> count=4, in_ready=0; hold in_valid with 1001 and pop=1 one cycle -> 1001 not accepted, count=3, in_ready=1 next cycle.
- Framing errors: from IDLE accept 1001 -> not stored, drop_err high one cycle; accept 0111 -> dropped, drop_err pulse, state IDLE; then header 1101 -> stored, count=1.
- Wrap and concurrency: stream 12 flits (header then payloads) with pop asserted every cycle after the first -> count stays 1, head_flit sequence matches input order across pointer wrap, no drop_err.
- Reset mid-packet: 2 flits stored, state PKT, rst_n low one cycle -> count=0, head_flit=0000; subsequent payload 1000 -> dropped with drop_err pulse.

Source files
------------

// File: rtl/input_channel_buffer.sv
// Per-input-channel flit buffer: framing filter in front of a circular FIFO
// whose oldest entry is presented to the output-port allocator as head_flit.
module input_channel_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 in_flit,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [3:0]                 head_flit,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] TYPE_NULL     = 2'b00;
    localparam logic [1:0] TYPE_RESERVED = 2'b01;
    localparam logic [1:0] TYPE_PAYLOAD  = 2'b10;
    localparam logic [1:0] TYPE_HEADER   = 2'b11;

    // Handshake: a flit transfers on a rising edge where in_valid & in_ready
    // are both high; in_ready depends only on the stored count.
    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic           drop_q;

    logic           accept;
    logic           store;
    logic           drop;
    logic           pop_ok;
    logic [1:0]     flit_type;

    assign flit_type = in_flit[3:2];
    assign accept    = in_valid & in_ready;
    assign pop_ok    = pop & (cnt != '0);

    always_comb begin
        state_next = state;
        store      = 1'b0;
        drop       = 1'b0;
        if (accept) begin
            case (flit_type)
                TYPE_HEADER: begin
                    store      = 1'b1;
                    state_next = PKT;
                end
                TYPE_PAYLOAD: begin
                    if (state == PKT) begin
                        store = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                TYPE_NULL: begin
                    state_next = IDLE;
                end
                TYPE_RESERVED: begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Storage is deliberately not reset; the count gates what is visible.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop;
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({store, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Full blocks acceptance even when a pop is in the same cycle.
    assign in_ready  = (cnt != FULL_COUNT);
    assign head_flit = (cnt != '0) ? mem[rd_ptr] : 4'b0000;
    assign count     = cnt;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_input_channel_buffer.sv
// Randomised and directed bench for input_channel_buffer with a queue-based
// reference model and a negedge monitor.
module tb_input_channel_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [3:0]    in_flit;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    head_flit;
    logic          pop;
    logic [CW-1:0] count;
    logic          drop_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [3:0] exp_q[$];
    int         m_count   = 0;
    bit         m_in_pkt  = 0;
    bit         exp_drop  = 0;
    bit         armed     = 0;
    int         drops_seen = 0;

    input_channel_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .head_flit (head_flit),
        .pop       (pop),
        .count     (count),
        .drop_err  (drop_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: packets are headers followed by payloads; anything else is
    // either a silent terminator (null) or a counted drop.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_count  = 0;
            m_in_pkt = 0;
            exp_drop = 0;
            armed    = 1;
        end else if (armed) begin
            bit acc, st, dr, pop_ok;
            acc    = in_valid && (m_count < DEPTH);
            pop_ok = pop && (m_count > 0);
            st = 0;
            dr = 0;
            if (acc) begin
                if (in_flit[3:2] == 2'b11) begin
                    st = 1; m_in_pkt = 1;
                end else if (in_flit[3:2] == 2'b10) begin
                    if (m_in_pkt) st = 1; else dr = 1;
                end else if (in_flit[3:2] == 2'b00) begin
                    m_in_pkt = 0;
                end else begin
                    dr = 1; m_in_pkt = 0;
                end
            end
            if (st) exp_q.push_back(in_flit);
            m_count  = m_count + int'(st) - int'(pop_ok);
            exp_drop = dr;
        end
    end

    // Monitor: compares visible outputs and retires the head on each pop.
    always @(negedge clk) begin
        if (armed) begin
            logic [3:0] exp_head;
            exp_head = (exp_q.size() > 0) ? exp_q[0] : 4'b0000;
            check("count", int'(count), m_count);
            check("in_ready", int'(in_ready), int'(m_count < DEPTH));
            check("drop_err", int'(drop_err), int'(exp_drop));
            check("head_flit", int'(head_flit), int'(exp_head));
            if (drop_err === 1'b1) drops_seen++;
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic drive(input bit v, input logic [3:0] f, input bit p);
        in_valid = v;
        in_flit  = f;
        pop      = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 4'b0000, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int drops_before;
        in_valid = 0;
        in_flit  = 0;
        pop      = 0;
        rst_n    = 0;

        // reset then idle
        do_reset(2);
        idle(1);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_count", int'(count), 0);
        check("reset_head", int'(head_flit), 0);

        // packet in, then drain including one pop on empty
        drive(1, 4'b1110, 0);
        drive(1, 4'b1000, 0);
        drive(1, 4'b1000, 0);
        drive(1, 4'b0000, 0);
        check("pkt_count", int'(count), 3);
        check("pkt_head", int'(head_flit), 4'b1110);
        for (int i = 0; i < 4; i++) drive(0, 4'b0000, 1);
        check("drained_count", int'(count), 0);

        // fill, then offer a flit with pop while full
        drive(1, 4'b1101, 0);
        drive(1, 4'b1001, 0);
        drive(1, 4'b1010, 0);
        drive(1, 4'b1011, 0);
        check("full_count", int'(count), DEPTH);
        check("full_ready", int'(in_ready), 0);
        drive(1, 4'b1001, 1);
        check("full_pop_count", int'(count), DEPTH - 1);
        check("full_pop_ready", int'(in_ready), 1);
        for (int i = 0; i < 3; i++) drive(0, 4'b0000, 1);
        drive(1, 4'b0000, 0);

        // framing errors from IDLE
        drops_before = drops_seen;
        drive(1, 4'b1001, 0);
        drive(1, 4'b0111, 0);
        drive(1, 4'b1101, 0);
        idle(1);
        check("err_drops", drops_seen - drops_before, 2);
        check("err_count", int'(count), 1);
        drive(0, 4'b0000, 1);
        drive(1, 4'b0000, 0);

        // streaming across pointer wrap
        drops_before = drops_seen;
        drive(1, 4'b1100, 0);
        for (int i = 1; i < 12; i++) begin
            drive(1, {2'b10, 2'(i)}, 1);
            check("stream_count", int'(count), 1);
        end
        drive(0, 4'b0000, 1);
        check("stream_drops", drops_seen - drops_before, 0);

        // reset mid-packet
        drive(1, 4'b1111, 0);
        drive(1, 4'b1000, 0);
        do_reset(1);
        check("midrst_count", int'(count), 0);
        check("midrst_head", int'(head_flit), 0);
        drops_before = drops_seen;
        drive(1, 4'b1000, 0);
        idle(1);
        check("midrst_drop", drops_seen - drops_before, 1);
        check("midrst_nostore", int'(count), 0);

        // random traffic with varying pop pressure
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 150; i++) begin
                logic [3:0] f;
                bit v, p;
                int r;
                r = $urandom_range(0, 9);
                if (r < 3)      f = {2'b11, 2'($urandom_range(0, 3))};
                else if (r < 7) f = {2'b10, 2'($urandom_range(0, 3))};
                else if (r < 9) f = {2'b00, 2'($urandom_range(0, 3))};
                else            f = {2'b01, 2'($urandom_range(0, 3))};
                v = ($urandom_range(0, 3) != 0);
                p = ($urandom_range(0, 3) < phase + 1);
                if ($urandom_range(0, 99) == 0) begin
                    do_reset(1);
                end else begin
                    drive(v, f, p);
                end
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
